// File: rtl/stch_dec_pkg.sv
// Shared types, default sizing and the count-to-binary scaling helper for
// the stochastic output decoder.
//   state_t   : decoder FSM states
//   WIN_LEN   : samples per decode window (default sizing)
//   CNT_W     : per-channel ones-counter width, able to hold WIN_LEN
//   IDX_W     : width of a channel index
//   sat_scale : drop the extra count LSBs and clamp to the output width
package stch_dec_pkg;

    localparam int unsigned NCH_DEF      = 5;
    localparam int unsigned DP_OUT_DEF   = 8;
    localparam int unsigned WIN_LOG2_DEF = 8;

    localparam int unsigned WIN_LEN = 1 << WIN_LOG2_DEF;
    localparam int unsigned CNT_W   = WIN_LOG2_DEF + 1;
    localparam int unsigned IDX_W   = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        DONE
    } state_t;

    // A full window of ones yields exactly 2^WIN_LOG2, one past the largest
    // representable value, so the shifted count is clamped.
    function automatic logic [31:0] sat_scale(input logic [31:0]  cnt,
                                              input int unsigned  shift,
                                              input int unsigned  width);
        logic [31:0] shifted;
        logic [31:0] max_val;
        shifted = cnt >> shift;
        max_val = (32'd1 << width) - 32'd1;
        return (shifted > max_val) ? max_val : shifted;
    endfunction

endpackage

// File: rtl/stch_ones_counter.sv
// Per-channel ones counter for one stochastic bitstream.
//   CLK    : clock
//   INIT   : asynchronous active-high reset
//   clear  : synchronous clear at the start of a window
//   inc_en : sample strobe; adds s_bit when high
//   s_bit  : stochastic input bit for this channel
//   cnt    : number of ones seen since the last clear
module stch_ones_counter
    import stch_dec_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             clear,
    input  logic             inc_en,
    input  logic             s_bit,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc_en) begin
            cnt <= cnt + WIDTH'(s_bit);
        end
    end

endmodule

// File: rtl/stch_output_decoder.sv
// Stochastic-to-binary output decoder with argmax class selection.
// Counts ones per channel over 2^WIN_LOG2 enabled cycles, scales each count
// to DP_OUT bits, scans for the largest value (lowest index wins ties) and
// presents the result with a one-cycle VALID pulse.
//   CLK   : clock
//   INIT  : asynchronous active-high reset
//   START : begin a decode window (accepted only in IDLE)
//   EN    : sample enable; freezes sampling and the window counter when low
//   S     : one stochastic bit per channel
//   BUSY  : high whenever not IDLE
//   D     : decoded values, channel k at [k*DP_OUT +: DP_OUT]
//   CLASS : index of the largest decoded value
//   VALID : one-cycle pulse when D and CLASS update
module stch_output_decoder
    import stch_dec_pkg::*;
#(
    parameter  int unsigned NCH       = NCH_DEF,
    parameter  int unsigned DP_OUT    = DP_OUT_DEF,
    parameter  int unsigned WIN_LOG2  = WIN_LOG2_DEF,
    localparam int unsigned IDX_WIDTH = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  CLK,
    input  logic                  INIT,
    input  logic                  START,
    input  logic                  EN,
    input  logic [NCH-1:0]        S,
    output logic                  BUSY,
    output logic [NCH*DP_OUT-1:0] D,
    output logic [IDX_WIDTH-1:0]  CLASS,
    output logic                  VALID
);

    localparam int unsigned CNT_WIDTH   = WIN_LOG2 + 1;
    localparam int unsigned WIN_SAMPLES = 1 << WIN_LOG2;
    localparam int unsigned SHIFT       = WIN_LOG2 - DP_OUT;

    state_t state_q, state_d;

    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 last_sample;
    logic                 scan_last;
    logic [CNT_WIDTH-1:0] win_cnt_q;
    logic [CNT_WIDTH-1:0] cnt     [NCH];
    logic [DP_OUT-1:0]    val     [NCH];
    logic [DP_OUT-1:0]    res_q   [NCH];
    logic [IDX_WIDTH-1:0] scan_idx_q;
    logic [IDX_WIDTH-1:0] max_idx_q;
    logic [DP_OUT-1:0]    max_val_q;

    // ---------------------------------------------------------------------
    // Per-channel ones counters
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        stch_ones_counter #(
            .WIDTH(CNT_WIDTH)
        ) u_cnt (
            .CLK    (CLK),
            .INIT   (INIT),
            .clear  (cnt_clear),
            .inc_en (cnt_inc),
            .s_bit  (S[g]),
            .cnt    (cnt[g])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            val[k] = DP_OUT'(sat_scale(32'(cnt[k]), SHIFT, DP_OUT));
        end
    end

    assign last_sample = (win_cnt_q == CNT_WIDTH'(WIN_SAMPLES - 1));
    assign scan_last   = (scan_idx_q == IDX_WIDTH'(NCH - 1));

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START)              state_d = ACCUM;
            ACCUM:   if (EN && last_sample)  state_d = SCAN;
            SCAN:    if (scan_last)          state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state_q != IDLE);
        cnt_clear = (state_q == IDLE) && START;
        cnt_inc   = (state_q == ACCUM) && EN;
    end

    // ---------------------------------------------------------------------
    // Window counter
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            win_cnt_q <= '0;
        end else if (cnt_clear) begin
            win_cnt_q <= '0;
        end else if (cnt_inc) begin
            win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Result latch and argmax scan
    // ---------------------------------------------------------------------
    // The counters settle on the ACCUM-exit edge, so the latch is loaded on
    // the first SCAN cycle, which also seeds the running max with channel 0.
    // Later scan steps then compare against the latched values.
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            scan_idx_q <= '0;
            max_idx_q  <= '0;
            max_val_q  <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                res_q[k] <= '0;
            end
        end else if (state_q == SCAN) begin
            scan_idx_q <= scan_last ? '0 : scan_idx_q + 1'b1;
            if (scan_idx_q == '0) begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    res_q[k] <= val[k];
                end
                max_val_q <= val[0];
                max_idx_q <= '0;
            end else if (res_q[scan_idx_q] > max_val_q) begin
                max_val_q <= res_q[scan_idx_q];
                max_idx_q <= scan_idx_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            D     <= '0;
            CLASS <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= (state_q == DONE);
            if (state_q == DONE) begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    D[k*DP_OUT +: DP_OUT] <= res_q[k];
                end
                CLASS <= max_idx_q;
            end
        end
    end

endmodule
